mem_arbiter: RTL
================

# mem_arbiter

Parametrised arbiter that shares one multi-cycle main memory (pipelined, fixed read latency, `data_valid` return strobe) among `NUM_CH` cache clients. It generalises the two-way icache/dcache select mux in the CPU top level to N channels, with round-robin fairness and ownership held for a whole block fill. Ownership is not released until every outstanding read has returned. It sits between the cache FSMs (`iCache`, `dCache`, future L1 clients) and `memory4c`.

## Interface
Parameters:
- `NUM_CH`, 2: number of client channels, 2..8
- `ADDR_W`, 16: address width
- `DATA_W`, 16: data width
- `MEM_LAT`, 4: maximum reads in flight in memory; sizes the outstanding counter

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_CH  per-channel access request, held for the whole transaction (block fill or write)
- `wr`  in  NUM_CH  per-channel write qualifier
- `addr`  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- `wdata`  in  NUM_CH*DATA_W  per-channel write data, same packing as `addr`
- `gnt`  out  NUM_CH  one-hot ownership, registered
- `rdata`  out  DATA_W  read data broadcast to all channels
- `rvalid`  out  NUM_CH  read-data strobe for the owning channel only
- `err`  out  1  sticky flag: `mem_valid` arrived with zero reads outstanding
- `mem_en`  out  1  memory enable
- `mem_wr`  out  1  memory write
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `mem_valid`  in  1  memory read-data strobe

## Operation
- State machine with three states: IDLE, GRANT, DRAIN.
- **IDLE:**
  - `gnt`=0 and `mem_en`=0.
  - If any `req` bit is set, select a winner, register `gnt`=onehot(winner), update `rr_ptr` to (winner+1) mod NUM_CH, and go to GRANT.
- **Winner selection:** the first set `req` bit searching upward from `rr_ptr`, wrapping at NUM_CH.
- **GRANT:**
  - `mem_en` = req[own]; `mem_wr` = req[own] & wr[own].
  - `mem_addr` and `mem_wdata` are muxed combinationally from the owning channel.
  - A read issue is `mem_en & ~mem_wr`.
  - When req[own] drops: go to IDLE if `outstanding`==0, otherwise go to DRAIN. `gnt` clears on the same edge in both cases.
- **DRAIN:**
  - `mem_en`=0; `gnt` stays 0.
  - Returning data is still routed to the previous owner.
  - Go to IDLE when `outstanding` reaches 0.
- **outstanding counter:**
  - Width $clog2(MEM_LAT+1).
  - +1 on a read issue, −1 on `mem_valid`, unchanged when both occur in the same cycle.
  - Saturates at MEM_LAT. A read issue at MEM_LAT is not counted and sets `err`.
- **Read return:** `rdata` = `mem_rdata` always. `rvalid`[i] = `mem_valid` & (owner==i) & (state≠IDLE).
- **err:**
  - Set by `mem_valid` with `outstanding`==0 (the strobe is dropped: no `rvalid`, counter stays 0).
  - Set by counter overflow.
  - Cleared only by reset.

## Timing
- **Reset values:** `gnt`=0, `rvalid`=0, `err`=0, `mem_en`=0, `mem_wr`=0. `mem_addr`/`mem_wdata` show channel 0. State=IDLE, `rr_ptr`=0, `outstanding`=0, owner=0.
- **Arbitration latency:** `req` rising in cycle 0 while IDLE gives `gnt` in cycle 1; the first `mem_en` is in cycle 1.
- **Back-to-back transactions:** one IDLE bubble cycle minimum between owners, or between successive transactions of the same owner.
- **Read data path:** combinational, zero added latency. A read issued in cycle k returns in cycle k+memory latency.
- **Requests during GRANT or DRAIN:** other channels' `req` is ignored and is evaluated in the next IDLE.
- **Reset mid-transaction:** takes effect immediately, asynchronously. In-flight returns after reset release are counted as spurious and set `err`. Clients must be reset together with the arbiter.
- **`req` dropped in the grant cycle before any access:** go directly to IDLE.

## Configuration
- **`MEM_ARB_FIXED_PRIO_EN` defined:**
  - Winner is the lowest-indexed set `req` bit; `rr_ptr` is unused and held at 0.
  - Channel 0 (icache) always wins, matching current CPU behaviour.
- **Undefined (default):** round-robin as described in Operation.

## Test plan
- **Round-robin rotation:** NUM_CH=2; both `req` held high from reset release, each owner issuing 1 read then dropping `req` after its return → grant order 0,1,0,1; `gnt` one-hot; an IDLE bubble between each grant.
- **Block fill:** ch1 issues 8 reads at addresses 0x0100..0x010E in consecutive cycles, MEM_LAT=4 → outstanding peaks at 4; `rvalid`[1] is asserted 8 times in the correct order; `rvalid`[0] never asserts.
- **Drain:** ch0 drops `req` immediately after its 4th read → state DRAIN for 4 cycles with `gnt`=0 and `mem_en`=0; ch1 granted the cycle after IDLE.
- **Write pass-through:** ch1 writes 0xBEEF to 0x0040 → `mem_en`=`mem_wr`=1, `mem_addr`=0x0040, `mem_wdata`=0xBEEF in the grant cycle; `outstanding` stays 0.
- **Spurious strobe and async reset:** inject `mem_valid` in IDLE → `err`=1 and no `rvalid`; then assert `rst_n`=0 mid-GRANT → all outputs at reset values immediately; `err`=0.
- **MEM_ARB_FIXED_PRIO_EN build, NUM_CH=4:** `req`=4'b1110 then 4'b1111 → ch1 granted, then ch0 granted on the next arbitration.

Source files
------------

// File: rtl/mem_arbiter.sv
// N-channel arbiter sharing one pipelined main memory among cache clients.
// Default build is round-robin; define MEM_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest).
module mem_arbiter #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          wr,
  input  logic [NUM_CH*ADDR_W-1:0]   addr,
  input  logic [NUM_CH*DATA_W-1:0]   wdata,
  output logic [NUM_CH-1:0]          gnt,
  output logic [DATA_W-1:0]          rdata,
  output logic [NUM_CH-1:0]          rvalid,
  output logic                       err,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_valid
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  owner, owner_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]  outstanding, outstanding_nxt;
  logic [NUM_CH-1:0] gnt_nxt;
  logic              err_nxt;

  logic [ADDR_W-1:0] addr_ch  [NUM_CH];
  logic [DATA_W-1:0] wdata_ch [NUM_CH];

  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cand;
  logic              any_req;
  logic              req_own;
  logic              wr_own;
  logic              read_issue;
  logic              ret_ok;

  // Unpack the flat per-channel buses
  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      addr_ch[i]  = addr[i*ADDR_W +: ADDR_W];
      wdata_ch[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // Winner search; later loop iterations overwrite, so the highest-priority hit is visited last
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_req = |req;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
`else
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      cand = IDX_W'((32'(rr_ptr) + 32'(k)) % NUM_CH);
      if (req[cand]) winner = cand;
    end
`endif
  end

  assign req_own    = req[owner];
  assign wr_own     = wr[owner];
  assign mem_en     = (state == GRANT) && req_own;
  assign mem_wr     = mem_en && wr_own;
  assign mem_addr   = addr_ch[owner];
  assign mem_wdata  = wdata_ch[owner];
  assign read_issue = mem_en && !wr_own;
  assign ret_ok     = mem_valid && (outstanding != '0);
  assign rdata      = mem_rdata;

  // Returns go to the current or most recent owner; strobes with nothing outstanding are dropped
  always_comb begin
    rvalid = '0;
    if (ret_ok && (state != IDLE)) rvalid[owner] = 1'b1;
  end

  // Ownership state machine
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    gnt_nxt    = gnt;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (any_req) begin
          owner_nxt       = winner;
          gnt_nxt[winner] = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
          rr_ptr_nxt      = '0;
`else
          rr_ptr_nxt      = IDX_W'((32'(winner) + 32'd1) % NUM_CH);
`endif
          state_nxt       = GRANT;
        end
      end
      GRANT: begin
        if (!req_own) begin
          gnt_nxt   = '0;
          state_nxt = (outstanding == '0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        gnt_nxt = '0;
        if (outstanding == '0) state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Reads in flight; an issue and a return in the same cycle cancel out
  always_comb begin
    outstanding_nxt = outstanding;
    err_nxt         = err;
    if (mem_valid && (outstanding == '0)) err_nxt = 1'b1;
    if (read_issue && !ret_ok) begin
      if (outstanding == CNT_W'(MEM_LAT)) err_nxt = 1'b1;
      else                                outstanding_nxt = outstanding + 1'b1;
    end else if (ret_ok && !read_issue) begin
      outstanding_nxt = outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      outstanding <= '0;
      gnt         <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      outstanding <= outstanding_nxt;
      gnt         <= gnt_nxt;
      err         <= err_nxt;
    end
  end

endmodule
